// File: rtl/man_decode.sv
// man_decode: Manchester line decoder with hunt/lock mid-bit tracking.
// Emits one registered data_valid strobe per decoded bit and an err strobe on loss of lock.
module man_decode #(
    parameter int HALF = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic man_sig_in,
    output logic data_out,
    output logic data_valid,
    output logic locked,
    output logic err
);
    localparam int BIT = 2 * HALF;
    localparam int LO  = 3 * BIT / 4;
    localparam int HI  = 5 * BIT / 4;
    localparam int LIM = HI + 1;
    localparam int W   = $clog2(LIM + 1);
    localparam logic [W-1:0] LO_V  = W'(LO);
    localparam logic [W-1:0] HI_V  = W'(HI);
    localparam logic [W-1:0] LIM_V = W'(LIM);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t       state, state_n;
    logic         s1, s2, s3;
    logic [W-1:0] cnt, cnt_n, elapsed;
    logic         edge_det, in_win, accept, lost;

    // elapsed is the cycle count to the edge being judged, so the window is a direct edge spacing
    always_comb begin
        edge_det = s2 ^ s3;
        elapsed  = (&cnt) ? cnt : cnt + 1'b1;
        in_win   = (elapsed >= LO_V) && (elapsed <= HI_V);
        state_n  = state;
        cnt_n    = elapsed;
        accept   = 1'b0;
        lost     = 1'b0;
        if (state == HUNT) begin
            if (edge_det) begin
                cnt_n   = '0;
                accept  = in_win;
                state_n = in_win ? LOCKED : HUNT;
            end
        end else if (edge_det && in_win) begin
            cnt_n  = '0;
            accept = 1'b1;
        end else if (elapsed == LIM_V) begin
            lost    = 1'b1;
            state_n = HUNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            state      <= HUNT;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            s1         <= man_sig_in;
            s2         <= s1;
            s3         <= s2;
            cnt        <= cnt_n;
            state      <= state_n;
            data_valid <= accept;
            err        <= lost;
            locked     <= (state_n == LOCKED);
            if (accept)
                data_out <= ~s2;
        end
    end
endmodule

// File: doc/man_decode.md
MAN_DECODE -- requirements
Module: man_decode

Interface
REQ-001 The block SHALL have parameter HALF, default 8, meaning clk cycles per Manchester half-bit; legal range 4..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port man_sig_in, input, 1, the Manchester line, asynchronous to clk.
REQ-005 The block SHALL have port data_out, output, 1, the decoded bit, valid only when data_valid=1.
REQ-006 The block SHALL have port data_valid, output, 1, a one-cycle strobe per decoded bit.
REQ-007 The block SHALL have port locked, output, 1, high while in LOCKED state.
REQ-008 The block SHALL have port err, output, 1, a one-cycle strobe on loss of lock.

Function
REQ-009 Line code SHALL be: bit 1 = high-then-low, bit 0 = low-then-high, mid-bit transition always present; BIT = 2*HALF cycles.
REQ-010 man_sig_in SHALL pass a 2-flop synchronizer (s1, s2) plus history flop s3; edge = s2 XOR s3.
REQ-011 A counter cnt SHALL clear to 0 in any cycle an edge is accepted, else increment, saturating at its maximum; width SHALL hold 5*BIT/4+1.
REQ-012 Acceptance window SHALL be 3*BIT/4 <= cnt <= 5*BIT/4 (HALF=8: 12..20 inclusive).
REQ-013 States SHALL be HUNT and LOCKED only.
REQ-014 HUNT: every edge SHALL clear cnt; an edge inside the window SHALL be taken as mid-bit, emit a bit, and move to LOCKED.
REQ-015 HUNT: edges outside the window SHALL emit nothing and not change state.
REQ-016 LOCKED: edges with cnt below the window (bit-boundary edges) SHALL be ignored and SHALL NOT clear cnt.
REQ-017 LOCKED: an edge inside the window SHALL emit a bit and clear cnt.
REQ-018 LOCKED: when cnt reaches 5*BIT/4+1 with no accepted edge, err SHALL pulse one cycle, locked SHALL fall in the same cycle, state SHALL become HUNT.
REQ-019 Emitted bit value SHALL be NOT s2 at the accepted edge (falling mid-bit edge -> 1, rising -> 0).
REQ-020 data_out, data_valid, locked and err SHALL be registered; the strobe for a mid-bit transition that meets setup before clk edge k SHALL be high for exactly the cycle following edge k+2.
REQ-021 data_out SHALL hold its last value between strobes.
REQ-022 The block SHALL decode continuously with no frame or byte boundaries; err and data_valid SHALL never be high together.
REQ-023 A constant line in HUNT SHALL produce no strobes and no err.

Reset
REQ-024 While rst=1: s1, s2, s3 = 0, cnt = 0, state = HUNT, data_out = 0, data_valid = 0, locked = 0, err = 0.
REQ-025 Reset asserted mid-bit or mid-lock SHALL abort immediately without err pulse; after release decoding SHALL restart from HUNT, first bit needing a fresh in-window edge.

Verification
REQ-026 HALF=8, rst pulse, then line driven with ideal 16-cycle bits 1,0,1,1,0 -> first mid-bit edge ignored in HUNT (no prior edge), then locked rises and data_valid strobes report the following bits in order with correct values, one strobe per bit.
REQ-027 Alternating pattern 0,1,0,1 (no boundary edges, edges every 16 cycles) -> lock on second edge, data_out alternates 1,0,1,... per REQ-019.
REQ-028 While locked, hold line constant 30 cycles -> err single pulse at cnt=21, locked=0 same cycle, no data_valid; resume valid data -> relock on next in-window edge.
REQ-029 Jitter: mid-bit edges spaced 12 and 20 cycles -> accepted; spaced 11 (after a boundary edge omitted) or 21 -> rejected/err as per REQ-016/018.
REQ-030 Assert rst for 1 cycle while locked mid-stream -> all outputs 0 asynchronously, no err; stream continues -> relock and correct decoding.
REQ-031 Idle constant 0 and constant 1 for 200 cycles each after reset -> no data_valid, no err, locked=0.
